// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types for the synchronous fifo
package fifo_pkg;

  // Accepted operation for one cycle, after full/empty gating.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push_ok, input logic pop_ok);
    return fifo_op_e'({pop_ok, push_ok});
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH register array, sync write, comb read
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  // Storage is deliberately not reset; only control state is.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock fifo with registered read data and full/empty flags
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic [WIDTH-1:0] rd_data;
  logic             push_ok, pop_ok;
  fifo_op_e         op;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (push_data_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    push_ok    = push_i & ~full_o;
    pop_ok     = pop_i & ~empty_o;
    op         = fifo_op(push_ok, pop_ok);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop_data_d = pop_data_q;

    // Wrap by compare so non power-of-two depths work.
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      pop_data_d = rd_data;
    end

    case (op)
      OP_PUSH: count_d = count_q + CNT_W'(1);
      OP_POP:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pop_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pop_data_q <= pop_data_d;
    end
  end

  assign pop_data_o = pop_data_q;
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - scoreboard bench for fifo (WIDTH=32, DEPTH=4)
module tb_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             push_i = 1'b0;
  logic [WIDTH-1:0] push_data_i = '0;
  logic             pop_i = 1'b0;
  logic [WIDTH-1:0] pop_data_o;
  logic             full_o;
  logic             empty_o;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_data = '0;

  fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .pop_i       (pop_i),
    .pop_data_o  (pop_data_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".pop_data"}, pop_data_o, exp_data);
    check_eq({tag, ".empty"}, WIDTH'(empty_o), WIDTH'(sb_q.size() == 0));
    check_eq({tag, ".full"}, WIDTH'(full_o), WIDTH'(sb_q.size() == DEPTH));
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk_i);
    rst_i  = 1'b0;
    push_i = 1'b1;
    push_data_i = 32'hdead_beef;
    pop_i  = 1'b1;
    @(posedge clk_i);
    #1;
    sb_q.delete();
    exp_data = '0;
    check_state(tag);
    @(negedge clk_i);
    rst_i  = 1'b1;
    push_i = 1'b0;
    pop_i  = 1'b0;
  endtask

  task automatic cycle(input string tag, input logic p, input logic [WIDTH-1:0] d,
                       input logic q);
    logic wok, rok;
    @(negedge clk_i);
    push_i      = p;
    push_data_i = d;
    pop_i       = q;
    wok = p && (sb_q.size() != DEPTH);
    rok = q && (sb_q.size() != 0);
    @(posedge clk_i);
    #1;
    if (rok) exp_data = sb_q.pop_front();
    if (wok) sb_q.push_back(d);
    check_state(tag);
  endtask

  initial begin
    apply_reset("reset");
    cycle("pop_empty", 1'b0, '0, 1'b1);

    cycle("push10", 1'b1, 32'd10, 1'b0);
    cycle("pop10", 1'b0, '0, 1'b1);
    cycle("idle_hold", 1'b0, '0, 1'b0);

    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 32'(10 + 2 * i), 1'b0);
    cycle("push_full", 1'b1, 32'd99, 1'b0);
    cycle("full_push_pop", 1'b1, 32'd77, 1'b1);
    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, '0, 1'b1);

    for (int i = 0; i < 3; i++) cycle("fill3", 1'b1, 32'(20 + i), 1'b0);
    for (int i = 0; i < 6; i++) cycle("wrap_both", 1'b1, 32'(30 + i), 1'b1);
    for (int i = 0; i < 3; i++) cycle("drain3", 1'b0, '0, 1'b1);
    cycle("empty_both", 1'b1, 32'd55, 1'b1);
    cycle("after_both", 1'b0, '0, 1'b1);

    cycle("pre_rst_a", 1'b1, 32'd61, 1'b0);
    cycle("pre_rst_b", 1'b1, 32'd62, 1'b0);
    cycle("pre_rst_c", 1'b0, '0, 1'b1);
    apply_reset("mid_reset");
    cycle("post_rst_pop", 1'b0, '0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      cycle("random", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle("final_drain", 1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
